clock_tick_gen: RTL and testbench
=================================

// Module: clock_tick_gen
// PURPOSE
//  Upstream timing stage of the 24-hour digital clock. Divides the single board clock into the
//  1 Hz timekeeping clock and the 500 Hz display-multiplex clock that drive seg_counter.
//  Emits 50%-duty square waves for the clk_1hz/clk_500hz inputs, plus matching 1-cycle tick pulses.
//  Adds run/pause, a fast-forward mode for time setting and simulation, and a phase clear.
// PARAMETERS
//  CLK_HZ     100_000_000  board clock frequency, Hz
//  SLOW_HZ    1            timekeeping output frequency, Hz
//  MUX_HZ     500          display multiplex output frequency, Hz
//  FAST_MULT  60           speed-up factor applied to the slow divider while fast=1
// PORTS
//  clk         in   1   board clock, all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  run         in   1   1 = slow divider counts; 0 = slow divider frozen
//  fast        in   1   1 = slow divider period divided by FAST_MULT
//  clear       in   1   sync pulse: restart slow phase from zero
//  clk_1hz     out  1   slow square wave, 50% duty (to seg_counter clk_1hz)
//  clk_500hz   out  1   mux square wave, 50% duty (to seg_counter clk_500hz)
//  tick_1hz    out  1   1-cycle pulse on each clk_1hz rising transition
//  tick_500hz  out  1   1-cycle pulse on each clk_500hz rising transition
// BEHAVIOUR
//  - Constants: HALF_S = CLK_HZ/(2*SLOW_HZ), HALF_F = HALF_S/FAST_MULT, HALF_M = CLK_HZ/(2*MUX_HZ).
//    Counter width = $clog2(HALF_S). Elaboration error if HALF_M < 1, HALF_F < 1, or FAST_MULT < 1.
//  - Reset (rst=1 at posedge): both counters 0; clk_1hz, clk_500hz, tick_1hz, tick_500hz all 0.
//    rst overrides every other input.
//  - Divider step: count 0..HALF-1. On the edge where count==HALF-1: count<=0 and square toggles.
//    Otherwise count<=count+1. Square period = 2*HALF cycles. Outputs are registers, no glitches.
//  - Tick: asserted for exactly one cycle, registered on the same edge that drives the square 0->1.
//    The tick is high during the first cycle that the square is high. No tick on 1->0 transitions.
//  - First edge: clk_500hz rises HALF_M cycles after reset release. clk_1hz rises HALF_S cycles after
//    reset release (HALF_F when fast=1).
//  - Mux divider: always free-running. It ignores run, fast and clear, so the display keeps scanning.
//  - run=0: slow counter, clk_1hz and tick state hold. tick_1hz is 0 while paused.
//    Resume continues from the held count.
//  - fast: the slow terminal count is HALF_F-1 while fast=1, else HALF_S-1. It is sampled every cycle.
//    On a fast 0->1 switch with count >= HALF_F-1, the next counting edge is treated as terminal:
//    count<=0 and the square toggles. The count never runs past the active terminal.
//  - clear=1: slow count<=0, clk_1hz<=0, tick_1hz<=0 on that edge, regardless of run or fast.
//    clear beats a coincident terminal count. The mux divider is unaffected.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Shared package clock_pkg: functions computing HALF_S/HALF_F/HALF_M and the counter width.
//    Also holds the default frequency constants shared with seg_counter-level top.
//  - One sub-module tick_divider: counter, square register and rise-tick register.
//    Ports: clk, rst, en, clr, term[W-1:0], sq, tick. Instantiated twice.
//    Slow instance: en=run, clr=clear, term muxed by fast. Mux instance: en=1, clr=0, term=HALF_M-1.
// TESTING  (bench params: CLK_HZ=1000, SLOW_HZ=1, MUX_HZ=100, FAST_MULT=50 -> HALF_S=500, HALF_F=10, HALF_M=5)
//  - Reset release, run=1, fast=0: clk_500hz toggles every 5 cycles with first rise at cycle 5.
//    tick_500hz pulses every 10 cycles. clk_1hz first rise at cycle 500, tick_1hz once per 1000 cycles.
//  - Hold rst for 3 cycles mid-count: the cycle after, all outputs 0 and both counters 0.
//    The mux first rise is again 5 cycles after release.
//  - run=0 at slow count 200 for 300 cycles: clk_1hz constant and tick_1hz never asserted.
//    The mux still toggles every 5 cycles. After run=1, clk_1hz toggles 300 cycles later.
//  - fast=1 from reset: clk_1hz period 20 cycles. Raise fast at slow count 300: toggle on the next
//    edge, then period 20 cycles.
//  - clear at slow count 499 (terminal): clk_1hz stays 0, no tick_1hz, count 0. Next rise 500 cycles later.
//  - Check on every cycle: tick_x == (sq_x & ~sq_x_prev) for both dividers. Both squares hold 50% duty
//    over 10 periods.

Source files
------------

// File: rtl/clock_pkg.sv
// Purpose : shared frequency defaults and divider sizing helpers for the clock front end.
// Latency : n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
//
// Contents:
//   DEF_*                 default board / output frequencies, shared with the seg_counter-level top
//   half_period()         board cycles per half period of an output frequency
//   fast_half()           half period of the slow divider while fast-forwarding
//   cnt_width()           counter width able to hold 0..half-1 (never narrower than 1 bit)
package clock_pkg;

  localparam int DEF_CLK_HZ    = 100_000_000;
  localparam int DEF_SLOW_HZ   = 1;
  localparam int DEF_MUX_HZ    = 500;
  localparam int DEF_FAST_MULT = 60;

  // A zero or negative output frequency yields 0, which the top rejects at elaboration.
  function automatic int half_period(input int clk_hz, input int out_hz);
    if (out_hz < 1) return 0;
    return clk_hz / (2 * out_hz);
  endfunction

  // A zero or negative multiplier yields 0, which the top rejects at elaboration.
  function automatic int fast_half(input int half_s, input int mult);
    if (mult < 1) return 0;
    return half_s / mult;
  endfunction

  // $clog2(half) bits hold half-1; a half period of 1 still needs a 1-bit counter.
  function automatic int cnt_width(input int half);
    if (half < 2) return 1;
    return $clog2(half);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Purpose : counter-based divider producing a 50% square wave and a 1-cycle rise tick.
// Latency : square toggles on the edge where count reaches term; tick is registered on that same edge.
// Backpressure: none; en=0 freezes count and square (tick forced low), clr restarts the phase.
//
// Ports:
//   clk   in      board clock, all state on posedge
//   rst   in      synchronous active-high reset (beats everything)
//   en    in      1 = count advances
//   clr   in      synchronous phase clear, beats a coincident terminal count
//   term  in [W]  terminal count (half period - 1); may change at any cycle
//   sq    out     registered square wave
//   tick  out     registered pulse, high during the first cycle sq is high
module tick_divider
  import clock_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         sq,
  output logic         tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      sq   <= 1'b0;
      tick <= 1'b0;
    end else if (!en) begin
      // Paused: count and square hold, but a held tick would read as a second rise.
      tick <= 1'b0;
    end else if (cnt >= term) begin
      // ">=" rather than "==": if term drops below the current count (fast switch),
      // the very next counting edge becomes terminal instead of wrapping the counter.
      cnt  <= '0;
      sq   <= ~sq;
      tick <= ~sq;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_tick_gen.sv
// Purpose : divides the board clock into the 1 Hz timekeeping and 500 Hz display-mux clocks.
// Latency : all outputs registered; first mux rise HALF_M cycles and first slow rise HALF_S
//           (HALF_F when fast) cycles after reset release.
// Backpressure: none; run pauses only the slow divider, the mux divider always free-runs.
//
// Ports:
//   clk         in   board clock
//   rst         in   synchronous active-high reset
//   run         in   1 = slow divider counts, 0 = slow divider frozen
//   fast        in   1 = slow half period divided by FAST_MULT (sampled every cycle)
//   clear       in   pulse: restart the slow phase from zero
//   clk_1hz     out  slow 50% square wave
//   clk_500hz   out  mux 50% square wave
//   tick_1hz    out  1-cycle pulse on each clk_1hz rise
//   tick_500hz  out  1-cycle pulse on each clk_500hz rise
module clock_tick_gen
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int SLOW_HZ   = DEF_SLOW_HZ,
  parameter int MUX_HZ    = DEF_MUX_HZ,
  parameter int FAST_MULT = DEF_FAST_MULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic fast,
  input  logic clear,
  output logic clk_1hz,
  output logic clk_500hz,
  output logic tick_1hz,
  output logic tick_500hz
);

  localparam int HALF_S = half_period(CLK_HZ, SLOW_HZ);
  localparam int HALF_F = fast_half(HALF_S, FAST_MULT);
  localparam int HALF_M = half_period(CLK_HZ, MUX_HZ);

  // The slow counter is sized for the normal half period; the fast one is always shorter.
  // The mux divider gets its own width so a mux half period longer than HALF_S cannot truncate.
  localparam int WS = cnt_width(HALF_S);
  localparam int WM = cnt_width(HALF_M);

  generate
    if (FAST_MULT < 1) begin : g_bad_mult
      $error("clock_tick_gen: FAST_MULT must be >= 1");
    end
    if (HALF_S < 1) begin : g_bad_half_s
      $error("clock_tick_gen: CLK_HZ/(2*SLOW_HZ) must be >= 1");
    end
    if (HALF_F < 1) begin : g_bad_half_f
      $error("clock_tick_gen: HALF_S/FAST_MULT must be >= 1");
    end
    if (HALF_M < 1) begin : g_bad_half_m
      $error("clock_tick_gen: CLK_HZ/(2*MUX_HZ) must be >= 1");
    end
  endgenerate

  localparam logic [WS-1:0] TERM_S = WS'(HALF_S - 1);
  localparam logic [WS-1:0] TERM_F = WS'(HALF_F - 1);
  localparam logic [WM-1:0] TERM_M = WM'(HALF_M - 1);

  // fast only steers the terminal compare inside the divider; it never reaches an output
  // without passing through a register.
  logic [WS-1:0] slow_term;
  assign slow_term = fast ? TERM_F : TERM_S;

  tick_divider #(
    .W (WS)
  ) u_slow (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (clear),
    .term (slow_term),
    .sq   (clk_1hz),
    .tick (tick_1hz)
  );

  // Display scanning must never stop, so the mux divider ignores run, fast and clear.
  tick_divider #(
    .W (WM)
  ) u_mux (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .clr  (1'b0),
    .term (TERM_M),
    .sq   (clk_500hz),
    .tick (tick_500hz)
  );

endmodule

// File: tb/tb_clock_tick_gen.sv
// Self-checking bench for clock_tick_gen with a scaled-down board clock.
module tb_clock_tick_gen;

  localparam int CLK_HZ    = 1000;
  localparam int SLOW_HZ   = 1;
  localparam int MUX_HZ    = 100;
  localparam int FAST_MULT = 50;
  localparam int HS = 500;
  localparam int HF = 10;
  localparam int HM = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b1;
  logic fast = 1'b0;
  logic clear = 1'b0;
  logic clk_1hz, clk_500hz, tick_1hz, tick_500hz;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clock_tick_gen #(
    .CLK_HZ    (CLK_HZ),
    .SLOW_HZ   (SLOW_HZ),
    .MUX_HZ    (MUX_HZ),
    .FAST_MULT (FAST_MULT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .fast       (fast),
    .clear      (clear),
    .clk_1hz    (clk_1hz),
    .clk_500hz  (clk_500hz),
    .tick_1hz   (tick_1hz),
    .tick_500hz (tick_500hz)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model.
  // Mux: closed form from the number of edges since reset release.
  // Slow: elapsed cycles within the current half period; a half period lasts
  // HS (or HF while fast) counted cycles, pauses do not elapse, clear restarts low.
  bit m_valid = 1'b0;
  int m_n = 0;
  int s_elapsed = 0;
  bit s_lvl = 1'b0;
  bit s_tick = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_n = 0;
      s_elapsed = 0;
      s_lvl = 1'b0;
      s_tick = 1'b0;
    end else begin
      m_n++;
      if (clear) begin
        s_elapsed = 0;
        s_lvl = 1'b0;
        s_tick = 1'b0;
      end else if (!run) begin
        s_tick = 1'b0;
      end else begin
        s_elapsed++;
        if (s_elapsed >= (fast ? HF : HS)) begin
          s_elapsed = 0;
          s_lvl = !s_lvl;
          s_tick = s_lvl;
        end else begin
          s_tick = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus the rise-tick invariant.
  logic p1 = 1'b0;
  logic p5 = 1'b0;
  always @(negedge clk) begin
    if (m_valid) begin
      check("sq_1hz",     int'(clk_1hz),    int'(s_lvl));
      check("tick_1hz",   int'(tick_1hz),   int'(s_tick));
      check("sq_500hz",   int'(clk_500hz),  (m_n / HM) % 2);
      check("tick_500hz", int'(tick_500hz), int'(m_n % (2 * HM) == HM));
      check("rise_1hz",   int'(tick_1hz),   int'(clk_1hz & ~p1));
      check("rise_500hz", int'(tick_500hz), int'(clk_500hz & ~p5));
      p1 = clk_1hz;
      p5 = clk_500hz;
    end
  end

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles, input logic f);
    rst = 1'b1;
    fast = f;
    run = 1'b1;
    clear = 1'b0;
    repeat (cycles) nxt();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_m, first_s, second_s;
    int c_a, c_b, c_c, c_d, c_e;

    // Reset state, then free run with run=1, fast=0.
    rst = 1'b1;
    repeat (3) nxt();
    check("reset_outputs", int'({clk_1hz, clk_500hz, tick_1hz, tick_500hz}), 0);
    rst = 1'b0;
    first_m = -1; first_s = -1;
    c_a = 0; c_b = 0; c_c = 0; c_d = 0; c_e = 0;
    for (int i = 1; i <= 10000; i++) begin
      nxt();
      if (first_m < 0 && clk_500hz) first_m = i;
      if (first_s < 0 && clk_1hz) first_s = i;
      if (i <= 100) begin
        c_a += int'(tick_500hz);
        c_b += int'(clk_500hz);
      end
      c_c += int'(tick_1hz);
      c_d += int'(clk_1hz);
      c_e += int'(clk_500hz);
    end
    check("first_mux_rise", first_m, 5);
    check("first_slow_rise", first_s, 500);
    check("mux_ticks_100", c_a, 10);
    check("mux_high_100", c_b, 50);
    check("slow_ticks_10000", c_c, 10);
    check("slow_high_10000", c_d, 5000);
    check("mux_high_10000", c_e, 5000);

    // Mid-count reset held 3 cycles, then pause at slow count 200 for 300 cycles.
    repeat (123) nxt();
    rst = 1'b1;
    repeat (3) nxt();
    check("midreset_outputs", int'({clk_1hz, clk_500hz, tick_1hz, tick_500hz}), 0);
    rst = 1'b0;
    first_m = -1; first_s = -1;
    c_a = 0; c_b = 0; c_c = 0;
    for (int i = 1; i <= 1000; i++) begin
      nxt();
      if (first_m < 0 && clk_500hz) first_m = i;
      if (first_s < 0 && clk_1hz) first_s = i;
      if (i > 200 && i <= 500) begin
        c_a += int'(tick_1hz);
        c_b += int'(clk_1hz);
        c_c += int'(tick_500hz);
      end
      if (i == 200) run = 1'b0;
      if (i == 500) run = 1'b1;
    end
    check("midreset_mux_rise", first_m, 5);
    check("pause_slow_ticks", c_a, 0);
    check("pause_slow_high", c_b, 0);
    check("pause_mux_ticks", c_c, 30);
    check("resume_slow_rise", first_s, 800);

    // fast=1 from reset: 20-cycle slow period.
    do_reset(2, 1'b1);
    first_s = -1; second_s = -1;
    for (int i = 1; i <= 60; i++) begin
      nxt();
      if (tick_1hz) begin
        if (first_s < 0) first_s = i;
        else if (second_s < 0) second_s = i;
      end
    end
    check("fast_first_rise", first_s, 10);
    check("fast_second_rise", second_s, 30);

    // Raise fast at slow count 300: next edge is terminal.
    do_reset(2, 1'b0);
    first_s = -1; second_s = -1;
    for (int i = 1; i <= 400; i++) begin
      nxt();
      if (tick_1hz) begin
        if (first_s < 0) first_s = i;
        else if (second_s < 0) second_s = i;
      end
      if (i == 300) fast = 1'b1;
    end
    check("fastswitch_first_rise", first_s, 301);
    check("fastswitch_second_rise", second_s, 321);

    // clear at slow count 499 beats the terminal count.
    do_reset(2, 1'b0);
    first_s = -1;
    for (int i = 1; i <= 1100; i++) begin
      nxt();
      if (first_s < 0 && clk_1hz) first_s = i;
      if (i == 499) clear = 1'b1;
      if (i == 500) begin
        check("clear_sq", int'(clk_1hz), 0);
        check("clear_tick", int'(tick_1hz), 0);
        clear = 1'b0;
      end
    end
    check("clear_next_rise", first_s, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
